// File: rtl/dm_pkg.sv
// Shared debug-module package: DMI request/response payload types used on
// both sides of the buffer stage. No ports; types only.
package dm;

  typedef enum logic [1:0] {
    DTM_NOP   = 2'h0,
    DTM_READ  = 2'h1,
    DTM_WRITE = 2'h2
  } dtm_op_e;

  typedef struct packed {
    logic [6:0]  addr;
    dtm_op_e     op;
    logic [31:0] data;
  } dmi_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;

endpackage

// File: rtl/dmi_buf_stage_pkg.sv
// Constants and helpers shared by the DMI buffer stage and its FIFO.
// No ports.
package dmi_buf_stage_pkg;

  localparam int MIN_DEPTH = 1;
  localparam int MAX_DEPTH = 16;

  function automatic bit depth_ok(input int depth);
    return (depth >= MIN_DEPTH) && (depth <= MAX_DEPTH);
  endfunction

  // Pointer width; a single-entry FIFO still carries a 1-bit pointer that
  // simply stays at 0.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dmi_fifo.sv
// Generic in-order FIFO with registered output, used once per DMI path.
// Ports:
//   clk_i, rst_ni   clock, synchronous active-low reset
//   flush_i         empties the FIFO at the edge, blocks input while high
//   in_data_i/in_valid_i/in_ready_o     push side
//   out_data_o/out_valid_o/out_ready_i  pop side
//   count_o         registered occupancy
// Handshake: a beat transfers on a clock edge where valid && ready; valid
// never depends on ready, and a held beat keeps its payload stable.
module dmi_fifo
  import dmi_buf_stage_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = ptr_width(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [CW-1:0]    count_o
);

  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("dmi_fifo: DEPTH must be within 1..16");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push;
  logic             pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
  endfunction

  assign out_valid_o = (count_q != '0);
  assign out_data_o  = mem_q[rd_ptr_q];
  assign count_o     = count_q;

  // Accepting while full is safe when the head leaves in the same cycle.
  assign in_ready_o  = !flush_i && ((count_q < CW'(DEPTH)) || out_ready_i);
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i && !flush_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= in_data_i;
        wr_ptr_q        <= next_ptr(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= next_ptr(rd_ptr_q);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
    end
  end

endmodule

// File: rtl/dmi_buf_stage.sv
// DMI buffer stage: decouples a DMI source (debug transport) from its
// destination (debug module) with one FIFO on the request path and one on
// the response path, plus a one-cycle registered copy of the clear signal.
// Ports:
//   clk_i, rst_ni                         clock, synchronous active-low reset
//   dmi_clear_i / dmi_clear_o             flush in, registered flush out
//   dmi_req_i/_valid_i/_ready_o           request from source
//   dmi_req_o/_valid_o/_ready_i           request to destination
//   dmi_resp_i/_valid_i/_ready_o          response from destination
//   dmi_resp_o/_valid_o/_ready_i          response to source
//   req_count_o, resp_count_o             registered FIFO occupancy
module dmi_buf_stage
  import dmi_buf_stage_pkg::*;
#(
  parameter int REQ_DEPTH  = 2,
  parameter int RESP_DEPTH = 2
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            dmi_clear_i,
  input  dm::dmi_req_t                    dmi_req_i,
  input  logic                            dmi_req_valid_i,
  output logic                            dmi_req_ready_o,
  output dm::dmi_resp_t                   dmi_resp_o,
  output logic                            dmi_resp_valid_o,
  input  logic                            dmi_resp_ready_i,
  output logic                            dmi_clear_o,
  output dm::dmi_req_t                    dmi_req_o,
  output logic                            dmi_req_valid_o,
  input  logic                            dmi_req_ready_i,
  input  dm::dmi_resp_t                   dmi_resp_i,
  input  logic                            dmi_resp_valid_i,
  output logic                            dmi_resp_ready_o,
  output logic [$clog2(REQ_DEPTH+1)-1:0]  req_count_o,
  output logic [$clog2(RESP_DEPTH+1)-1:0] resp_count_o
);

  localparam int REQ_W  = $bits(dm::dmi_req_t);
  localparam int RESP_W = $bits(dm::dmi_resp_t);

  logic [REQ_W-1:0]  req_data;
  logic [RESP_W-1:0] resp_data;

  dmi_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (REQ_DEPTH)
  ) i_req_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (dmi_clear_i),
    .in_data_i   (dmi_req_i),
    .in_valid_i  (dmi_req_valid_i),
    .in_ready_o  (dmi_req_ready_o),
    .out_data_o  (req_data),
    .out_valid_o (dmi_req_valid_o),
    .out_ready_i (dmi_req_ready_i),
    .count_o     (req_count_o)
  );

  dmi_fifo #(
    .WIDTH (RESP_W),
    .DEPTH (RESP_DEPTH)
  ) i_resp_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (dmi_clear_i),
    .in_data_i   (dmi_resp_i),
    .in_valid_i  (dmi_resp_valid_i),
    .in_ready_o  (dmi_resp_ready_o),
    .out_data_o  (resp_data),
    .out_valid_o (dmi_resp_valid_o),
    .out_ready_i (dmi_resp_ready_i),
    .count_o     (resp_count_o)
  );

  assign dmi_req_o  = dm::dmi_req_t'(req_data);
  assign dmi_resp_o = dm::dmi_resp_t'(resp_data);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) dmi_clear_o <= 1'b0;
    else         dmi_clear_o <= dmi_clear_i;
  end

endmodule

// File: tb/tb_dmi_buf_stage.sv
// Bench for dmi_buf_stage. Two instances share one stimulus stream:
// dut_a (REQ_DEPTH=2, RESP_DEPTH=2) and dut_b (REQ_DEPTH=3, RESP_DEPTH=1).
// Each of the four paths is modelled as a bounded queue of beats.
module tb_dmi_buf_stage;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          clear;
  dm::dmi_req_t  req;
  logic          req_valid, req_ready;
  dm::dmi_resp_t resp;
  logic          resp_valid, resp_ready;

  dm::dmi_req_t  a_req_o, b_req_o;
  dm::dmi_resp_t a_resp_o, b_resp_o;
  logic a_req_ready_o, a_resp_valid_o, a_clear_o, a_req_valid_o, a_resp_ready_o;
  logic b_req_ready_o, b_resp_valid_o, b_clear_o, b_req_valid_o, b_resp_ready_o;
  logic [1:0] a_req_cnt, a_resp_cnt, b_req_cnt;
  logic [0:0] b_resp_cnt;

  dmi_buf_stage #(.REQ_DEPTH(2), .RESP_DEPTH(2)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .dmi_clear_i(clear),
    .dmi_req_i(req), .dmi_req_valid_i(req_valid), .dmi_req_ready_o(a_req_ready_o),
    .dmi_resp_o(a_resp_o), .dmi_resp_valid_o(a_resp_valid_o), .dmi_resp_ready_i(resp_ready),
    .dmi_clear_o(a_clear_o),
    .dmi_req_o(a_req_o), .dmi_req_valid_o(a_req_valid_o), .dmi_req_ready_i(req_ready),
    .dmi_resp_i(resp), .dmi_resp_valid_i(resp_valid), .dmi_resp_ready_o(a_resp_ready_o),
    .req_count_o(a_req_cnt), .resp_count_o(a_resp_cnt)
  );

  dmi_buf_stage #(.REQ_DEPTH(3), .RESP_DEPTH(1)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .dmi_clear_i(clear),
    .dmi_req_i(req), .dmi_req_valid_i(req_valid), .dmi_req_ready_o(b_req_ready_o),
    .dmi_resp_o(b_resp_o), .dmi_resp_valid_o(b_resp_valid_o), .dmi_resp_ready_i(resp_ready),
    .dmi_clear_o(b_clear_o),
    .dmi_req_o(b_req_o), .dmi_req_valid_o(b_req_valid_o), .dmi_req_ready_i(req_ready),
    .dmi_resp_i(resp), .dmi_resp_valid_i(resp_valid), .dmi_resp_ready_o(b_resp_ready_o),
    .req_count_o(b_req_cnt), .resp_count_o(b_resp_cnt)
  );

  // ---------------- scoreboard ----------------
  // Paths: 0 = a.req, 1 = a.resp, 2 = b.req, 3 = b.resp
  logic [40:0] exp_q [4][$];
  int          dep [4] = '{2, 2, 3, 1};
  logic        exp_clear = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic set_idle();
    rst_n      = 1'b1;
    clear      = 1'b0;
    req_valid  = 1'b0;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_ready = 1'b0;
    req        = '0;
    resp       = '0;
  endtask

  task automatic rand_payload();
    req.addr  = 7'($urandom);
    req.op    = dm::dtm_op_e'(2'($urandom_range(0, 3)));
    req.data  = $urandom;
    resp.data = $urandom;
    resp.resp = 2'($urandom_range(0, 3));
  endtask

  // Called at a negedge with inputs already driven: checks every output
  // against the model, then advances the model across the next posedge.
  task automatic cycle();
    logic [40:0] obs_d [4];
    logic        obs_v [4];
    logic        obs_r [4];
    int          obs_c [4];
    logic [40:0] din   [4];
    logic        vin   [4];
    logic        ordy  [4];
    logic        ev    [4];
    logic        er    [4];
    #1;
    obs_d[0] = 41'(a_req_o);  obs_v[0] = a_req_valid_o;  obs_r[0] = a_req_ready_o;  obs_c[0] = int'(a_req_cnt);
    obs_d[1] = 41'(a_resp_o); obs_v[1] = a_resp_valid_o; obs_r[1] = a_resp_ready_o; obs_c[1] = int'(a_resp_cnt);
    obs_d[2] = 41'(b_req_o);  obs_v[2] = b_req_valid_o;  obs_r[2] = b_req_ready_o;  obs_c[2] = int'(b_req_cnt);
    obs_d[3] = 41'(b_resp_o); obs_v[3] = b_resp_valid_o; obs_r[3] = b_resp_ready_o; obs_c[3] = int'(b_resp_cnt);
    for (int i = 0; i < 4; i++) begin
      din[i]  = (i % 2 == 0) ? 41'(req) : 41'(resp);
      vin[i]  = (i % 2 == 0) ? req_valid : resp_valid;
      ordy[i] = (i % 2 == 0) ? req_ready : resp_ready;
      ev[i]   = (exp_q[i].size() != 0);
      er[i]   = !clear && ((exp_q[i].size() < dep[i]) || ordy[i]);
      check_eq($sformatf("p%0d_valid", i), 64'(obs_v[i]), 64'(ev[i]));
      check_eq($sformatf("p%0d_ready", i), 64'(obs_r[i]), 64'(er[i]));
      check_eq($sformatf("p%0d_count", i), 64'(obs_c[i]), 64'(exp_q[i].size()));
      if (ev[i]) check_eq($sformatf("p%0d_data", i), 64'(obs_d[i]), 64'(exp_q[i][0]));
    end
    check_eq("a_clear_o", 64'(a_clear_o), 64'(exp_clear));
    check_eq("b_clear_o", 64'(b_clear_o), 64'(exp_clear));

    if (!rst_n) begin
      exp_clear = 1'b0;
      for (int i = 0; i < 4; i++) exp_q[i].delete();
    end else begin
      exp_clear = clear;
      for (int i = 0; i < 4; i++) begin
        if (clear) exp_q[i].delete();
        else begin
          if (ev[i] && ordy[i]) void'(exp_q[i].pop_front());
          if (vin[i] && er[i])  exp_q[i].push_back(din[i]);
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [6:0] got_addr [$];
    int         first_v, last_v;
    bit         hi_ready;

    set_idle();
    rst_n = 1'b0;
    @(negedge clk);
    cycle();
    #1;
    check_eq("rst_a_req_o",  64'(a_req_o),  64'd0);
    check_eq("rst_a_resp_o", 64'(a_resp_o), 64'd0);

    // Two pushes into a stalled request path.
    set_idle(); req_valid = 1'b1; req.addr = 7'h10; cycle();
    req.addr = 7'h11; cycle();
    set_idle(); #1;
    check_eq("full_count", 64'(a_req_cnt), 64'd2);
    check_eq("full_ready", 64'(a_req_ready_o), 64'd0);
    check_eq("full_head",  64'(a_req_o.addr), 64'h10);
    cycle();

    // Push while full and draining in the same cycle.
    req_valid = 1'b1; req.addr = 7'h12; req_ready = 1'b1; #1;
    check_eq("passthru_ready", 64'(a_req_ready_o), 64'd1);
    cycle();
    set_idle(); #1;
    check_eq("passthru_count", 64'(a_req_cnt), 64'd2);
    check_eq("passthru_head",  64'(a_req_o.addr), 64'h11);
    cycle();
    req_ready = 1'b1; #1;
    check_eq("drain_0", 64'(a_req_o.addr), 64'h11);
    cycle(); #1;
    check_eq("drain_1", 64'(a_req_o.addr), 64'h12);
    repeat (3) cycle();

    // Ten back-to-back beats through the depth-3 path.
    got_addr.delete();
    first_v = -1; last_v = -1;
    for (int k = 0; k < 14; k++) begin
      set_idle(); req_ready = 1'b1;
      req_valid = (k < 10); req.addr = 7'(8'h20 + k); #1;
      if (b_req_valid_o) begin
        got_addr.push_back(b_req_o.addr);
        if (first_v < 0) first_v = k;
        last_v = k;
      end
      cycle();
    end
    check_eq("b2b_beats", 64'(got_addr.size()), 64'd10);
    check_eq("b2b_span",  64'(last_v - first_v + 1), 64'd10);
    for (int k = 0; k < got_addr.size(); k++)
      check_eq($sformatf("b2b_addr%0d", k), 64'(got_addr[k]), 64'(8'h20 + k));

    // Clear with two buffered responses and a pop in the same cycle.
    set_idle(); resp_valid = 1'b1; resp.data = 32'hA0; cycle();
    resp.data = 32'hA1; cycle();
    clear = 1'b1; resp_ready = 1'b1; req_valid = 1'b1; #1;
    check_eq("clr_resp_ready", 64'(a_resp_ready_o), 64'd0);
    check_eq("clr_req_ready",  64'(a_req_ready_o),  64'd0);
    cycle();
    set_idle(); #1;
    check_eq("clr_resp_count", 64'(a_resp_cnt), 64'd0);
    check_eq("clr_resp_valid", 64'(a_resp_valid_o), 64'd0);
    check_eq("clr_out_high",   64'(a_clear_o), 64'd1);
    cycle(); #1;
    check_eq("clr_out_low",    64'(a_clear_o), 64'd0);

    // Reset with both paths holding data.
    set_idle(); req_valid = 1'b1; resp_valid = 1'b1; rand_payload();
    repeat (2) cycle();
    set_idle(); rst_n = 1'b0; clear = 1'b1; cycle();
    set_idle(); #1;
    check_eq("rst2_req_cnt",   64'(a_req_cnt), 64'd0);
    check_eq("rst2_resp_cnt",  64'(a_resp_cnt), 64'd0);
    check_eq("rst2_req_valid", 64'(a_req_valid_o), 64'd0);
    check_eq("rst2_resp_valid",64'(b_resp_valid_o), 64'd0);
    check_eq("rst2_clear_o",   64'(a_clear_o), 64'd0);
    check_eq("rst2_req_o",     64'(a_req_o), 64'd0);
    cycle();

    // Random traffic with alternating drain-heavy and stall-heavy phases.
    for (int n = 0; n < 3000; n++) begin
      hi_ready   = ((n / 200) % 2) == 0;
      rst_n      = ($urandom_range(0, 299) != 0);
      clear      = ($urandom_range(0, 39) == 0);
      req_valid  = 1'($urandom_range(0, 1));
      resp_valid = 1'($urandom_range(0, 1));
      req_ready  = hi_ready ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      resp_ready = hi_ready ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      rand_payload();
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmi_buf_stage.md
DMI_BUF_STAGE -- requirements
Module: dmi_buf_stage

Interface
REQ-001 SHALL have parameter REQ_DEPTH, default 2, request-path buffer entries (legal range 1..16).
REQ-002 SHALL have parameter RESP_DEPTH, default 2, response-path buffer entries (legal range 1..16).
REQ-003 SHALL have one clock and a synchronous, active-low reset:
- clk_i  in  1  single clock for all state
- rst_ni  in  1  synchronous active-low reset
REQ-004 SHALL have the following ports:
- dmi_clear_i  in  1  flush request, source side
- dmi_req_i  in  dm::dmi_req_t  request payload, source side
- dmi_req_valid_i  in  1  request valid
- dmi_req_ready_o  out  1  request accepted
- dmi_resp_o  out  dm::dmi_resp_t  response payload to source
- dmi_resp_valid_o  out  1  response valid
- dmi_resp_ready_i  in  1  source accepts response
- dmi_clear_o  out  1  registered clear to destination
- dmi_req_o  out  dm::dmi_req_t  request to destination
- dmi_req_valid_o  out  1  request valid to destination
- dmi_req_ready_i  in  1  destination accepts request
- dmi_resp_i  in  dm::dmi_resp_t  response from destination
- dmi_resp_valid_i  in  1  response valid from destination
- dmi_resp_ready_o  out  1  response accepted
- req_count_o  out  $clog2(REQ_DEPTH+1)  request occupancy
- resp_count_o  out  $clog2(RESP_DEPTH+1)  response occupancy

Function
REQ-005 Each path SHALL be an in-order FIFO: push on in_valid && in_ready; pop on out_valid && out_ready.
REQ-006 Out valid SHALL be (count != 0); out payload SHALL be the head entry, driven from storage, never combinationally from the input.
REQ-007 Minimum latency SHALL be one cycle: payload pushed at edge N is presented at the output from edge N onward (visible in cycle N+1).
REQ-008 In ready SHALL be (count < DEPTH) || out_ready, so a simultaneous push and pop at full is accepted and count is unchanged.
REQ-009 Simultaneous push and pop at any occupancy SHALL leave count unchanged and advance both pointers.
REQ-010 Pointers SHALL wrap from DEPTH-1 to 0 for any DEPTH, including non-powers of two.
REQ-011 A pop at empty and a push when ready is low SHALL be no-ops; count SHALL never exceed DEPTH or underflow.
REQ-012 dmi_clear_o SHALL equal dmi_clear_i delayed by exactly one clock.
REQ-013 While dmi_clear_i=1, dmi_req_ready_o and dmi_resp_ready_o SHALL be 0, and inputs SHALL be ignored.
REQ-014 At each edge where dmi_clear_i=1, both FIFOs SHALL be emptied (counts 0, pointers 0), overriding any pop in that cycle.
REQ-015 req_count_o and resp_count_o SHALL reflect registered occupancy.
REQ-016 With DEPTH=1, ready SHALL be ~valid_q || out_ready, making it cycle-equivalent to a single-entry register slice.

Reset
REQ-017 When rst_ni=0 at a clock edge, all pointers, counts and dmi_clear_o SHALL go to 0; valids SHALL be 0 from the following cycle; payload outputs SHALL be '0.
REQ-018 Reset asserted mid-transfer SHALL discard all buffered entries, with no partial pop or push.
REQ-019 Storage arrays SHALL be reset to '0.

Structure
REQ-020 dm::dmi_req_t and dm::dmi_resp_t SHALL come from the shared dm package; no new typedefs are added.
REQ-021 A generic sub-module dmi_fifo (parameters WIDTH, DEPTH; ports clk_i, rst_ni, flush_i, push/pop handshake, count_o) SHALL be instantiated once per path.
REQ-022 An elaboration-time check SHALL reject DEPTH < 1 or DEPTH > 16.

Verification
REQ-023 REQ_DEPTH=2, dmi_req_ready_i=0, push addr 0x10 then addr 0x11 -> req_count_o=2, dmi_req_ready_o=0, and dmi_req_o.addr=0x10.
REQ-024 Full request FIFO, dmi_req_ready_i=1, and a push in the same cycle -> push accepted, req_count_o stays 2, output sequence is in order.
REQ-025 REQ_DEPTH=3, 10 back-to-back pushes with ready_i=1 -> 10 outputs in order, no gaps after first, pointers wrap.
REQ-026 resp FIFO holding 2 entries, then dmi_clear_i=1 for one cycle with a pop -> resp_count_o=0, dmi_resp_valid_o=0 the next cycle, dmi_clear_o=1 one cycle later.
REQ-027 rst_ni=0 for one edge with both FIFOs non-empty -> all counts 0, valids 0, dmi_clear_o=0.
REQ-028 DEPTH=1 random stall traffic -> cycle-identical to a single-entry register slice model.
